conn_tx_scheduler: RTL and testbench
====================================

CONN_TX_SCHEDULER -- requirements
Module: conn_tx_scheduler

Interface
REQ-001 The module SHALL have parameter NUM_CONN, default 32, giving the number of connection records scanned (1..32).
REQ-002 The module SHALL have parameter TIMEOUT_CYC, default 255, giving the build watchdog limit in cycles (1..255).
REQ-003 Ports SHALL be:
- clk  in  1  single clock; all logic on posedge.
- rst  in  1  asynchronous, active-low reset.
- sched_en  in  1  scan enable.
- ram_addr  out  8  connection RAM word address; record r, word w = {r[4:0], w[2:0]}.
- ram_wdata  out  32  connection RAM write data.
- ram_wren  out  1  connection RAM write enable.
- ram_rdata  in  32  connection RAM read data, valid one cycle after address.
- host_req  in  1  host access request.
- host_we  in  1  host write (1) or read (0).
- host_addr  in  8  host RAM address.
- host_wdata  in  32  host write data.
- host_gnt  out  1  host access performed this cycle.
- host_rdata  out  32  host read data.
- host_rvalid  out  1  host_rdata valid.
- bld_req  out  1  build request to the packet builder.
- bld_id  out  5  record id being built.
- bld_ack  in  1  builder accepted request.
- bld_word  in  3  word the builder is fetching.
- bld_done  in  1  builder finished, one-cycle pulse.
- bld_abort  out  1  watchdog abort pulse.

Function
REQ-004 Record word 0 SHALL be bit 31 = valid and bit 30 = tx_pending; all other bits are opaque and SHALL be preserved.
REQ-005 The FSM SHALL have states IDLE, RD0, CHK, REQ, BUILD, CLR and NEXT.
REQ-006 In IDLE with host_req=1, the block SHALL drive the host address, data and we onto the RAM, assert host_gnt for that cycle, and stay in IDLE.
REQ-007 A granted host read SHALL return host_rdata=ram_rdata with host_rvalid=1 exactly one cycle after host_gnt.
REQ-008 In IDLE with host_req=0 and sched_en=1, the FSM SHALL go to RD0; host_gnt SHALL be 0 in every state except IDLE.
REQ-009 In RD0 the block SHALL drive ram_addr={ptr,3'd0} with ram_wren=0, then go to CHK.
REQ-010 In CHK the block SHALL latch ram_rdata into word0_q.
- If bits 31 and 30 are both 1, the FSM SHALL go to REQ.
- Otherwise it SHALL go to NEXT.
REQ-011 In REQ, bld_req SHALL be 1 and bld_id=ptr; on bld_ack=1 the FSM SHALL go to BUILD.
REQ-012 In REQ, bld_req SHALL stay asserted and bld_id SHALL stay stable until bld_ack.
REQ-013 In BUILD, ram_addr SHALL be {ptr,bld_word} with ram_wren=0; on bld_done=1 the FSM SHALL go to CLR.
REQ-014 In CLR, the block SHALL write word0_q with bit 30 cleared to {ptr,3'd0} for one cycle, then go to NEXT.
REQ-015 In NEXT, ptr SHALL increment, wrap from NUM_CONN-1 to 0, and the FSM SHALL go to IDLE.
- Round-robin: at most one build per visit to IDLE.
REQ-016 Deasserting sched_en SHALL take effect only in IDLE; an in-progress scan or build SHALL complete.
REQ-017 bld_done arriving in any state other than BUILD SHALL be ignored.
REQ-018 ram_wren SHALL be 1 only in CLR or on a granted host write.

Reset
REQ-019 While rst=0, the block SHALL be in IDLE with ptr=0, word0_q=0, timeout counter=0, and all outputs 0.
REQ-020 Reset asserted mid-build SHALL drop bld_req and abandon the build with no CLR write.

Configuration
REQ-021 With SCHED_TIMEOUT_EN defined, an 8-bit counter SHALL run in BUILD and REQ, cleared on entry to each.
- On reaching TIMEOUT_CYC, bld_abort SHALL pulse for one cycle.
- The FSM SHALL then go to NEXT without a CLR write, leaving tx_pending set for retry.
REQ-022 With SCHED_TIMEOUT_EN undefined, the counter SHALL be absent, bld_abort SHALL be tied to 0, and BUILD and REQ SHALL wait indefinitely.

Verification
REQ-023 Record 3 word0=0xC000_0000, others 0, sched_en=1 -> first bld_req with bld_id=3; after bld_done, RAM[24]=0x8000_0000, then the scan continues at ptr=4.
REQ-024 All records valid+pending, builder acks and done immediately -> bld_id sequence 0..31,0 wraps; each record is cleared exactly once.
REQ-025 host_req held high in IDLE with a read of addr 0x10 holding 0xDEAD_BEEF -> host_gnt=1, then host_rvalid=1 with host_rdata=0xDEAD_BEEF next cycle; no scan starts while host_req=1.
REQ-026 host_req raised during BUILD -> host_gnt=0 until the FSM returns to IDLE, then the grant is issued.
REQ-027 SCHED_TIMEOUT_EN defined, TIMEOUT_CYC=10, builder never asserts done -> bld_abort pulses 10 cycles after BUILD entry; word0 stays 0xC000_0000.
REQ-028 rst asserted during BUILD for record 5 -> all outputs 0 immediately; after release, the scan restarts at ptr=0 and record 5 is still pending.

Source files
------------

// File: rtl/conn_tx_scheduler.sv
// Round-robin transmit scheduler: scans connection records and hands pending ones to the packet builder.
// Optional build watchdog enabled by defining SCHED_TIMEOUT_EN.
module conn_tx_scheduler #(
  parameter int NUM_CONN    = 32,
  parameter int TIMEOUT_CYC = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        sched_en,
  output logic [7:0]  ram_addr,
  output logic [31:0] ram_wdata,
  output logic        ram_wren,
  input  logic [31:0] ram_rdata,
  input  logic        host_req,
  input  logic        host_we,
  input  logic [7:0]  host_addr,
  input  logic [31:0] host_wdata,
  output logic        host_gnt,
  output logic [31:0] host_rdata,
  output logic        host_rvalid,
  output logic        bld_req,
  output logic [4:0]  bld_id,
  input  logic        bld_ack,
  input  logic [2:0]  bld_word,
  input  logic        bld_done,
  output logic        bld_abort
);

  typedef enum logic [2:0] {
    IDLE, RD0, CHK, REQ, BUILD, CLR, NEXT
  } state_t;

  localparam logic [4:0] LAST = 5'(NUM_CONN - 1);

  state_t      state_q, state_d;
  logic [4:0]  ptr_q;
  logic [31:0] word0_q;
  logic        rd_pend_q;
  logic        timeout;

`ifdef SCHED_TIMEOUT_EN
  localparam logic [7:0] LIMIT = 8'(TIMEOUT_CYC);
  logic [7:0] cnt_q;

  assign timeout = (state_q == REQ || state_q == BUILD)
                && (cnt_q == LIMIT);

  // Restarts on every state change, so REQ and BUILD each get a full budget.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)
      cnt_q <= 8'd0;
    else if (state_d != state_q)
      cnt_q <= 8'd0;
    else if (state_q == REQ || state_q == BUILD)
      cnt_q <= cnt_q + 8'd1;
  end
`else
  assign timeout = 1'b0;
`endif

  assign bld_abort   = timeout;
  assign host_rvalid = rd_pend_q;
  assign host_rdata  = rd_pend_q ? ram_rdata : 32'd0;

  always_comb begin
    state_d   = state_q;
    ram_addr  = 8'd0;
    ram_wdata = 32'd0;
    ram_wren  = 1'b0;
    host_gnt  = 1'b0;
    bld_req   = 1'b0;
    bld_id    = 5'd0;
    unique case (state_q)
      IDLE: begin
        // Gated by rst so every output reads 0 while reset is held.
        if (host_req && rst) begin
          host_gnt  = 1'b1;
          ram_addr  = host_addr;
          ram_wdata = host_wdata;
          ram_wren  = host_we;
        end else if (sched_en) begin
          state_d = RD0;
        end
      end
      RD0: begin
        ram_addr = {ptr_q, 3'd0};
        state_d  = CHK;
      end
      CHK: begin
        state_d = (ram_rdata[31:30] == 2'b11) ? REQ : NEXT;
      end
      REQ: begin
        bld_req = 1'b1;
        bld_id  = ptr_q;
        if (bld_ack)      state_d = BUILD;
        else if (timeout) state_d = NEXT;
      end
      BUILD: begin
        ram_addr = {ptr_q, bld_word};
        if (bld_done)     state_d = CLR;
        else if (timeout) state_d = NEXT;
      end
      CLR: begin
        ram_addr  = {ptr_q, 3'd0};
        ram_wdata = {word0_q[31], 1'b0, word0_q[29:0]};
        ram_wren  = 1'b1;
        state_d   = NEXT;
      end
      NEXT: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= IDLE;
      ptr_q     <= 5'd0;
      word0_q   <= 32'd0;
      rd_pend_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      rd_pend_q <= host_gnt & ~host_we;
      if (state_q == CHK)
        word0_q <= ram_rdata;
      if (state_q == NEXT)
        ptr_q <= (ptr_q == LAST) ? 5'd0 : ptr_q + 5'd1;
    end
  end

endmodule

// File: tb/tb_conn_tx_scheduler.sv
// Directed bench for conn_tx_scheduler with a behavioural connection RAM.
// Watchdog scenario is selected by SCHED_TIMEOUT_EN, matching the DUT build.
module tb_conn_tx_scheduler;

  logic        clk = 1'b0;
  logic        rst;
  logic        sched_en;
  logic [7:0]  ram_addr;
  logic [31:0] ram_wdata;
  logic        ram_wren;
  logic [31:0] ram_rdata;
  logic        host_req;
  logic        host_we;
  logic [7:0]  host_addr;
  logic [31:0] host_wdata;
  logic        host_gnt;
  logic [31:0] host_rdata;
  logic        host_rvalid;
  logic        bld_req;
  logic [4:0]  bld_id;
  logic        bld_ack;
  logic [2:0]  bld_word;
  logic        bld_done;
  logic        bld_abort;

  logic [31:0] mem [256];
  int          clr_cnt [32];
  int          n_checks = 0;
  int          n_pass = 0;

  conn_tx_scheduler #(.NUM_CONN(32), .TIMEOUT_CYC(10)) dut (
    .clk(clk), .rst(rst), .sched_en(sched_en),
    .ram_addr(ram_addr), .ram_wdata(ram_wdata),
    .ram_wren(ram_wren), .ram_rdata(ram_rdata),
    .host_req(host_req), .host_we(host_we),
    .host_addr(host_addr), .host_wdata(host_wdata),
    .host_gnt(host_gnt), .host_rdata(host_rdata),
    .host_rvalid(host_rvalid), .bld_req(bld_req),
    .bld_id(bld_id), .bld_ack(bld_ack),
    .bld_word(bld_word), .bld_done(bld_done),
    .bld_abort(bld_abort)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    ram_rdata <= mem[ram_addr];
    if (ram_wren) begin
      mem[ram_addr] = ram_wdata;
      if (!host_gnt) clr_cnt[ram_addr[7:3]] = clr_cnt[ram_addr[7:3]] + 1;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic wait_req(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk); #1;
      if (bld_req) begin ok = 1'b1; break; end
    end
  endtask

  task automatic do_build(input logic [4:0] exp_id);
    bit ok;
    wait_req(ok);
    n_checks++;
    if (!ok) $display("FAIL build_req: no bld_req seen, expected id %0d", exp_id);
    else if (bld_id !== exp_id) $display("FAIL build_id: got %0d exp %0d", bld_id, exp_id);
    else n_pass++;
    if (ok) begin
      bld_ack = 1'b1;
      @(negedge clk); bld_ack = 1'b0; bld_done = 1'b1;
      @(negedge clk); bld_done = 1'b0;
    end
  endtask

  task automatic idle_wait(input int n);
    for (int i = 0; i < n; i++) @(negedge clk);
  endtask

  task automatic test_reset;
    rst = 1'b0; sched_en = 1'b1; host_req = 1'b1; host_we = 1'b1;
    host_addr = 8'hAB; host_wdata = 32'h5555_AAAA;
    bld_ack = 1'b0; bld_done = 1'b0; bld_word = 3'd0;
    @(negedge clk); #1;
    n_checks++;
    if ({ram_addr, ram_wdata, ram_wren, host_gnt} !== 42'd0)
      $display("FAIL reset_ram: got addr %h wdata %h wren %b gnt %b exp 0",
               ram_addr, ram_wdata, ram_wren, host_gnt);
    else n_pass++;
    n_checks++;
    if ({host_rdata, host_rvalid, bld_req, bld_id, bld_abort} !== 40'd0)
      $display("FAIL reset_bld: got rvalid %b req %b id %0d abort %b exp 0",
               host_rvalid, bld_req, bld_id, bld_abort);
    else n_pass++;
    host_req = 1'b0; sched_en = 1'b0; rst = 1'b1;
    idle_wait(2);
  endtask

  task automatic test_host_access;
    mem[16] = 32'hDEAD_BEEF;
    sched_en = 1'b1; host_req = 1'b1; host_we = 1'b0; host_addr = 8'h10;
    @(negedge clk); #1;
    n_checks++;
    if (!(host_gnt === 1'b1 && ram_addr === 8'h10 && ram_wren === 1'b0))
      $display("FAIL host_gnt: got gnt %b addr %h wren %b exp 1 10 0", host_gnt, ram_addr, ram_wren);
    else n_pass++;
    @(negedge clk); #1;
    n_checks++;
    if (!(host_rvalid === 1'b1 && host_rdata === 32'hDEAD_BEEF))
      $display("FAIL host_rdata: got %b %h exp 1 deadbeef", host_rvalid, host_rdata);
    else n_pass++;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk); #1;
      n_checks++;
      if (!(bld_req === 1'b0 && ram_addr === 8'h10 && host_gnt === 1'b1))
        $display("FAIL host_hold: got req %b addr %h gnt %b exp 0 10 1", bld_req, ram_addr, host_gnt);
      else n_pass++;
    end
    host_we = 1'b1; host_addr = 8'h40; host_wdata = 32'h1234_5678; #1;
    n_checks++;
    if (ram_wren !== 1'b1) $display("FAIL host_wren: got %b exp 1", ram_wren);
    else n_pass++;
    @(negedge clk);
    host_req = 1'b0; sched_en = 1'b0; #1;
    n_checks++;
    if (!(host_rvalid === 1'b0 && mem[64] === 32'h1234_5678))
      $display("FAIL host_write: got rvalid %b mem %h exp 0 12345678", host_rvalid, mem[64]);
    else n_pass++;
    mem[16] = 32'd0; mem[64] = 32'd0;
    idle_wait(2);
  endtask

  task automatic test_first_build;
    bit ok;
    mem[24] = 32'hC000_0000;
    sched_en = 1'b1;
    wait_req(ok);
    n_checks++;
    if (!(ok && bld_id === 5'd3)) $display("FAIL first_id: got req %b id %0d exp 1 3", ok, bld_id);
    else n_pass++;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk); bld_done = (i == 0); #1;
      n_checks++;
      if (!(bld_req === 1'b1 && bld_id === 5'd3))
        $display("FAIL req_hold: got req %b id %0d exp 1 3", bld_req, bld_id);
      else n_pass++;
    end
    bld_done = 1'b0; bld_ack = 1'b1;
    @(negedge clk);
    bld_ack = 1'b0; bld_word = 3'd5;
    host_req = 1'b1; host_we = 1'b0; host_addr = 8'h10; #1;
    n_checks++;
    if (!(ram_addr === 8'h1D && ram_wren === 1'b0 && host_gnt === 1'b0))
      $display("FAIL build_fetch: got addr %h wren %b gnt %b exp 1d 0 0", ram_addr, ram_wren, host_gnt);
    else n_pass++;
    bld_done = 1'b1;
    @(negedge clk); bld_done = 1'b0; #1;
    n_checks++;
    if (!(ram_wren === 1'b1 && ram_addr === 8'h18 && ram_wdata === 32'h8000_0000 && host_gnt === 1'b0))
      $display("FAIL clr_write: got wren %b addr %h data %h gnt %b exp 1 18 80000000 0",
               ram_wren, ram_addr, ram_wdata, host_gnt);
    else n_pass++;
    @(negedge clk); #1;
    n_checks++;
    if (host_gnt !== 1'b0) $display("FAIL gnt_next: got %b exp 0", host_gnt);
    else n_pass++;
    @(negedge clk); #1;
    n_checks++;
    if (!(host_gnt === 1'b1 && ram_addr === 8'h10))
      $display("FAIL gnt_idle: got gnt %b addr %h exp 1 10", host_gnt, ram_addr);
    else n_pass++;
    @(negedge clk); host_req = 1'b0; #1;
    n_checks++;
    if (host_rvalid !== 1'b1) $display("FAIL gnt_rvalid: got %b exp 1", host_rvalid);
    else n_pass++;
    @(negedge clk); #1;
    n_checks++;
    if (!(ram_addr === 8'h20 && ram_wren === 1'b0))
      $display("FAIL next_ptr: got addr %h wren %b exp 20 0", ram_addr, ram_wren);
    else n_pass++;
    sched_en = 1'b0;
    idle_wait(5);
    n_checks++;
    if (mem[24] !== 32'h8000_0000) $display("FAIL rec3_clr: got %h exp 80000000", mem[24]);
    else n_pass++;
  endtask

  task automatic test_reset_mid_build;
    bit ok;
    mem[40] = 32'hC000_0000; mem[8] = 32'hC000_0000;
    sched_en = 1'b1;
    wait_req(ok);
    n_checks++;
    if (!(ok && bld_id === 5'd5)) $display("FAIL rst_build_id: got req %b id %0d exp 1 5", ok, bld_id);
    else n_pass++;
    bld_ack = 1'b1;
    @(negedge clk);
    bld_ack = 1'b0; host_req = 1'b1; host_we = 1'b1; host_addr = 8'h28; rst = 1'b0; #1;
    n_checks++;
    if ({bld_req, ram_wren, host_gnt, ram_addr, bld_id} !== 16'd0)
      $display("FAIL rst_mid: got req %b wren %b gnt %b addr %h exp all 0",
               bld_req, ram_wren, host_gnt, ram_addr);
    else n_pass++;
    idle_wait(2);
    rst = 1'b1; host_req = 1'b0;
    do_build(5'd1);
    n_checks++;
    if (mem[40] !== 32'hC000_0000) $display("FAIL rec5_kept: got %h exp c0000000", mem[40]);
    else n_pass++;
    do_build(5'd5);
    sched_en = 1'b0;
    idle_wait(4);
    n_checks++;
    if (!(mem[40] === 32'h8000_0000 && mem[8] === 32'h8000_0000))
      $display("FAIL rec5_clr: got %h %h exp 80000000 80000000", mem[40], mem[8]);
    else n_pass++;
  endtask

  task automatic test_round_robin;
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    for (int r = 0; r < 32; r++) begin
      mem[r*8] = 32'hC000_0000 | 32'(r);
      clr_cnt[r] = 0;
    end
    sched_en = 1'b1;
    for (int i = 0; i < 33; i++) begin
      do_build(5'(i % 32));
      if (i == 1) mem[0] = 32'hC000_0000;
    end
    sched_en = 1'b0;
    idle_wait(5);
    for (int r = 0; r < 32; r++) begin
      n_checks++;
      if (!(mem[r*8] === (32'h8000_0000 | 32'(r)) && clr_cnt[r] === ((r == 0) ? 2 : 1)))
        $display("FAIL rr_rec%0d: got %h clears %0d exp %h clears %0d",
                 r, mem[r*8], clr_cnt[r], 32'h8000_0000 | 32'(r), (r == 0) ? 2 : 1);
      else n_pass++;
    end
  endtask

  task automatic test_timeout;
    bit ok;
    int hit;
    int pulses;
    hit = -1; pulses = 0;
    mem[8] = 32'hC000_0001;
    sched_en = 1'b1;
    wait_req(ok);
    n_checks++;
    if (!(ok && bld_id === 5'd1)) $display("FAIL to_id: got req %b id %0d exp 1 1", ok, bld_id);
    else n_pass++;
    bld_ack = 1'b1;
    for (int n = 0; n < 40; n++) begin
      @(negedge clk); bld_ack = 1'b0; #1;
      if (bld_abort === 1'b1) begin
        pulses++;
        if (hit < 0) hit = n;
      end
    end
`ifdef SCHED_TIMEOUT_EN
    sched_en = 1'b0;
    idle_wait(5);
    n_checks++;
    if (!(hit == 10 && pulses == 1))
      $display("FAIL abort_time: got cycle %0d pulses %0d exp 10 1", hit, pulses);
    else n_pass++;
    n_checks++;
    if (!(mem[8] === 32'hC000_0001 && clr_cnt[1] === 1))
      $display("FAIL abort_keep: got %h clears %0d exp c0000001 1", mem[8], clr_cnt[1]);
    else n_pass++;
`else
    n_checks++;
    if (pulses != 0) $display("FAIL abort_off: got %0d pulses exp 0", pulses);
    else n_pass++;
    bld_done = 1'b1;
    @(negedge clk); bld_done = 1'b0;
    sched_en = 1'b0;
    idle_wait(4);
    n_checks++;
    if (!(mem[8] === 32'h8000_0001 && clr_cnt[1] === 2))
      $display("FAIL late_done: got %h clears %0d exp 80000001 2", mem[8], clr_cnt[1]);
    else n_pass++;
`endif
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 32'd0;
    for (int i = 0; i < 32; i++) clr_cnt[i] = 0;
    test_reset;
    test_host_access;
    test_first_build;
    test_reset_mid_build;
    test_round_robin;
    test_timeout;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
